// File: rtl/aes_key_expand.sv
// AES-128 round-key generator: produces round keys 0..NR one at a time on request.
// Optional round-key store enabled by defining AES_KEYEXP_STORE_EN.
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         valid,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_key
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_SUB   = 3'd2;
    localparam logic [2:0] S_MIX   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [3:0] LAST    = 4'(NR);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        logic [7:0] inv;
        x   = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            x   = gf_mul(x, x);
            inv = gf_mul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [2:0]   r_state;
    logic [127:0] r_round_key;
    logic [3:0]   r_round;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;
    logic [31:0]  r_sub;

    logic [31:0]  w_rot;
    logic [3:0]   w_round_inc;
    logic [31:0]  w_t;
    logic [31:0]  w_nw0;
    logic [31:0]  w_nw1;
    logic [31:0]  w_nw2;
    logic [31:0]  w_nw3;
    logic [127:0] w_next_key;

    assign w_rot       = {r_round_key[23:0], r_round_key[31:24]};
    assign w_round_inc = r_round + 4'd1;
    assign w_t         = r_sub ^ {rcon(w_round_inc), 24'h000000};
    assign w_nw0       = r_round_key[127:96] ^ w_t;
    assign w_nw1       = r_round_key[95:64]  ^ w_nw0;
    assign w_nw2       = r_round_key[63:32]  ^ w_nw1;
    assign w_nw3       = r_round_key[31:0]   ^ w_nw2;
    assign w_next_key  = {w_nw0, w_nw1, w_nw2, w_nw3};

    // The round key is stable from READY through MIX, so a free-running lookup is safe.
    always_ff @(posedge clk) begin
        r_sub <= {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_round_key <= '0;
            r_round     <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (start) begin
            r_state     <= S_READY;
            r_round_key <= key;
            r_round     <= '0;
            r_valid     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_READY: begin
                    if (next && (r_round < LAST)) begin
                        r_state <= S_SUB;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SUB: r_state <= S_MIX;
                S_MIX: begin
                    r_round_key <= w_next_key;
                    r_round     <= w_round_inc;
                    r_valid     <= 1'b1;
                    r_busy      <= 1'b0;
                    if (w_round_inc == LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_READY;
                    end
                end
                default: ;
            endcase
        end
    end

    assign round_key = r_round_key;
    assign round     = r_round;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef AES_KEYEXP_STORE_EN
    logic [127:0] r_store [0:10];
    logic [127:0] r_rd_key;

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (start) begin
                r_store[0] <= key;
            end else if (r_state == S_MIX) begin
                r_store[w_round_inc] <= w_next_key;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_key <= '0;
        end else begin
            r_rd_key <= (rd_addr <= 4'd10) ? r_store[rd_addr] : '0;
        end
    end

    assign rd_key = r_rd_key;
`else
    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^rd_addr;
    assign rd_key = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a word-level FIPS-197 key-schedule model.
module tb_aes_key_expand;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic         next;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic         valid;
    logic         busy;
    logic         done;
    logic [3:0]   rd_addr;
    logic [127:0] rd_key;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sb [256];

    aes_key_expand #(.NR(10)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .next(next),
        .round_key(round_key), .round(round), .valid(valid), .busy(busy),
        .done(done), .rd_addr(rd_addr), .rd_key(rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Walks p through powers of 3 while q tracks its inverse, filling the S-box table.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ xtime(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] ref_key(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h000000};
                rc  = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic do_start(input logic [127:0] k);
        key   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        key   = $urandom;
        check("start_valid", 128'(valid), 128'd1);
        check("start_round", 128'(round), 128'd0);
        check("start_key", round_key, k);
        check("start_done", 128'(done), 128'd0);
    endtask

    // Pulse next and wait (bounded) for the new key; spurious next pulses while busy must be ignored.
    task automatic step_round(input logic [127:0] k, input int exp_r, input bit noisy);
        int lat;
        next = 1'b1;
        tick();
        lat  = 1;
        check("step_busy", 128'(busy), 128'd1);
        next = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        while (!valid && lat < 20) begin
            tick();
            lat++;
            next = (!valid && noisy) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        next = 1'b0;
        check("step_latency", 128'(lat), 128'd3);
        check("step_round", 128'(round), 128'(exp_r));
        check("step_key", round_key, ref_key(k, exp_r));
        check("step_done", 128'(done), 128'(exp_r == 10));
    endtask

    initial begin
        logic [127:0] k;
        logic [127:0] hold_key;
        int           nr;
        reset   = 1'b1;
        start   = 1'b0;
        key     = '0;
        next    = 1'b0;
        rd_addr = '0;
        build_sbox();
        tick();
        tick();
        reset = 1'b0;
        check("rst_key", round_key, '0);
        check("rst_round", 128'(round), 128'd0);
        check("rst_valid", 128'(valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_rdkey", rd_key, '0);

        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        do_start(k);
        next = 1'b1;
        tick();
        next = 1'b0;
        check("fips_v_low1", 128'(valid), 128'd0);
        tick();
        check("fips_v_low2", 128'(valid), 128'd0);
        tick();
        check("fips_v_high", 128'(valid), 128'd1);
        check("fips_r1_round", 128'(round), 128'd1);
        check("fips_r1_key", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        for (int r = 2; r <= 10; r++) step_round(k, r, 1'b0);
        check("fips_r10_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        hold_key = round_key;
        next = 1'b1;
        tick();
        next = 1'b0;
        tick();
        tick();
        check("ign_round", 128'(round), 128'd10);
        check("ign_key", round_key, hold_key);
        check("ign_valid", 128'(valid), 128'd1);
        check("ign_busy", 128'(busy), 128'd0);
        check("ign_done", 128'(done), 128'd1);

`ifdef AES_KEYEXP_STORE_EN
        rd_addr = 4'd1;
        tick();
        check("store_r1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_addr = 4'd10;
        tick();
        check("store_r10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_addr = 4'd15;
        tick();
        check("store_oob", rd_key, '0);
`else
        rd_addr = 4'd1;
        tick();
        check("nostore_rdkey", rd_key, '0);
`endif

        // Restart mid-computation with a new key while in SUB.
        k = 128'h000102030405060708090a0b0c0d0e0f;
        do_start(k);
        for (int r = 1; r <= 3; r++) step_round(k, r, 1'b0);
        next = 1'b1;
        tick();
        next = 1'b0;
        check("abort_in_sub", 128'(busy), 128'd1);
        do_start('0);
        check("abort_busy", 128'(busy), 128'd0);
        step_round('0, 1, 1'b0);
        check("zero_r1_key", round_key, 128'h62636363626363636263636362636363);

        // Reset while in MIX at the round-5 step.
        do_start(k);
        for (int r = 1; r <= 4; r++) step_round(k, r, 1'b0);
        next = 1'b1;
        tick();
        next = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mixrst_valid", 128'(valid), 128'd0);
        check("mixrst_done", 128'(done), 128'd0);
        check("mixrst_round", 128'(round), 128'd0);
        check("mixrst_key", round_key, '0);
        next = 1'b1;
        tick();
        tick();
        next = 1'b0;
        tick();
        check("idle_next_valid", 128'(valid), 128'd0);
        check("idle_next_busy", 128'(busy), 128'd0);

        for (int it = 0; it < 8; it++) begin
            k  = {$urandom, $urandom, $urandom, $urandom};
            nr = $urandom_range(1, 10);
            do_start(k);
            for (int r = 1; r <= nr; r++) begin
                repeat ($urandom_range(0, 2)) tick();
                step_round(k, r, 1'b1);
            end
`ifdef AES_KEYEXP_STORE_EN
            for (int r = 0; r <= nr; r++) begin
                rd_addr = 4'(r);
                tick();
                check("rand_store", rd_key, ref_key(k, r));
            end
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Round-key generator directly upstream of the AES round datapath in the FPGA AES accelerator. Latches the 128-bit cipher key delivered over SPI and produces round keys 0..10 one at a time, advancing on request, per the FIPS-197 key schedule. The round-datapath controller requests each new key with `next` and consumes `round_key` when `valid` is high.

Parameters:
NR, 10, number of rounds; the last round index produced (AES-128 only; other values unsupported).

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
start  input  1  latch key, restart schedule at round 0
key  input  128  cipher key; byte 0 = key[127:120], w0 = key[127:96]
next  input  1  request next round key; honoured only when valid=1 and round<NR
round_key  output  128  current round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
round  output  4  index of round_key (0..10)
valid  output  1  round_key is stable and usable
busy  output  1  computing the next key
done  output  1  round 10 key is valid
rd_addr  input  4  stored-key read index (see Optional Feature)
rd_key  output  128  stored round key at rd_addr

Behaviour:
- Reset: state IDLE; round_key=0, round=0, valid=0, busy=0, done=0, rd_key=0. Reset mid-schedule aborts immediately.
- States: IDLE, READY, SUB, MIX, DONE.
- IDLE: outputs hold. On start, go to READY on the next edge with round_key=key, round=0, valid=1.
- READY: valid=1. On next with round<NR: valid=0 and busy=1 next cycle; state SUB; SubWord lookup issued on RotWord(w3) (bytes rotated left: b1,b2,b3,b0).
- S-box: four registered 256x8 lookups inside this block, one-cycle read latency.
- SUB: wait one cycle for the S-box output; go to MIX.
- MIX: compute t = SubWord(RotWord(w3)) XOR {rcon[round+1],24'h0}, then w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'. Register round_key and increment round.
- After MIX: valid=1 and busy=0; go to READY, or to DONE when round=NR.
- Latency: next sampled at edge t → valid=0 after t+1 → new key valid after edge t+3 (3 cycles).
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- DONE: done=1, valid=1, round=10. next is ignored.
- `next` while valid=0, or in IDLE, is ignored; there is no queuing.
- `start` is accepted in any state, including mid-computation. It takes priority over next, discards the in-flight computation, and reloads round 0 the next cycle (done clears).
- Simultaneous start and reset: reset wins.
- `key` is sampled only on a start edge; later changes have no effect.

Optional Feature:
AES_KEYEXP_STORE_EN
- Defined: an 11x128 register file captures each round key as it becomes valid (entry 0 on start). rd_key = entry[rd_addr], registered, one-cycle latency. rd_addr>10 returns 0. start clears no entries but overwrites them in sequence. Supports inverse-cipher reverse traversal after done.
- Undefined: no storage; rd_key is constant 0 and rd_addr is unused.

Test Plan:
- Reset, then start with key=2b7e151628aed2a6abf7158809cf4f3c → next cycle round=0, valid=1, round_key equals key, done=0.
- Same key, next pulsed at valid → valid low 2 cycles, then round=1 and round_key=a0fafe1788542cb123a339392a6c7605, exactly 3 cycles after next.
- Same key, next issued 10 times as soon as valid → round=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6, done=1. An 11th next leaves all outputs unchanged.
- start with key=000102030405060708090a0b0c0d0e0f, advance to round 3, then start with key=0 during SUB → in-flight result discarded; round=0, round_key=0. Round 1 then equals 62636363626363636263636362636363.
- Reset asserted in MIX state at round 5 → next cycle valid=0, done=0, round=0, round_key=0. next is ignored until start.
- With AES_KEYEXP_STORE_EN, run the FIPS key to done, then rd_addr=1 → rd_key=a0fafe1788542cb123a339392a6c7605 one cycle later. rd_addr=10 → d014f9a8c9ee2589e13f0cc8b6630ca6. rd_addr=15 → 0.
